// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the unified single-ported memory: fetch vs load/store,
// with alignment check and read-modify-write for sub-doubleword stores.
module mem_port_arbiter #(
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              IReq,
  input  logic [31:0]       IAddr,
  output logic              IAck,
  output logic [31:0]       IRData,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [31:0]       DAddr,
  input  logic [DATA_W-1:0] DWData,
  input  logic [1:0]        DTam,
  output logic              DAck,
  output logic [DATA_W-1:0] DRData,
  output logic              DErr,
  output logic [31:0]       MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWr,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Busy,
  output logic [2:0]        ArbState
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, CHK = 3'd1, RD = 3'd2, RMW_RD = 3'd3,
    RMW_WR = 3'd4, WR = 3'd5, ACK = 3'd6
  } state_t;

  state_t              state_q;
  logic                last_q;   // 1: fetch was granted last
  logic                gnt_q;    // 1: fetch owns the current cycle
  logic [1:0]          cnt_q;
  logic                iack_q, dack_q, derr_q, memwr_q;
  logic [31:0]         irdata_q, memaddr_q;
  logic [DATA_W-1:0]   drdata_q, memwdata_q;

  logic                misal, lat_done, dreq_eff, take_i;
  logic [5:0]          sh;
  logic [DATA_W-1:0]   lmask, ld_lane, merged;
  logic                unused_iaddr;

  assign unused_iaddr = ^IAddr[1:0];
  assign sh           = {DAddr[2:0], 3'b000};
  assign lat_done     = (cnt_q == 2'(MEM_LAT));
  // DReq is still up during its own DErr cycle; that is not a new request.
  assign dreq_eff     = DReq && !derr_q;
  assign take_i       = IReq && (!dreq_eff || !last_q);

  always_comb begin
    misal = 1'b0;
    lmask = '1;
    case (DTam)
      2'b00: begin misal = (DAddr[2:0] != 3'b000); lmask = '1; end
      2'b01: begin misal = (DAddr[1:0] != 2'b00);  lmask = DATA_W'(32'hFFFF_FFFF); end
      2'b10: begin misal = DAddr[0];               lmask = DATA_W'(16'hFFFF); end
      default: begin misal = 1'b0;                 lmask = DATA_W'(8'hFF); end
    endcase
    // Accesses past CHK are aligned, so one byte-offset shift serves every size.
    ld_lane = (MemRData >> sh) & lmask;
    merged  = (MemRData & ~(lmask << sh)) | ((DWData & lmask) << sh);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b0;
      gnt_q      <= 1'b0;
      cnt_q      <= '0;
      iack_q     <= 1'b0;
      dack_q     <= 1'b0;
      derr_q     <= 1'b0;
      memwr_q    <= 1'b0;
      irdata_q   <= '0;
      drdata_q   <= '0;
      memaddr_q  <= '0;
      memwdata_q <= '0;
    end else begin
      iack_q  <= 1'b0;
      dack_q  <= 1'b0;
      derr_q  <= 1'b0;
      memwr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take_i) begin
            gnt_q     <= 1'b1;
            memaddr_q <= {IAddr[31:3], 3'b000};
            cnt_q     <= '0;
            state_q   <= RD;
          end else if (dreq_eff) begin
            gnt_q   <= 1'b0;
            state_q <= CHK;
          end
        end
        CHK: begin
          if (misal) begin
            derr_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            memaddr_q <= {DAddr[31:3], 3'b000};
            cnt_q     <= '0;
            if (!DWe) begin
              state_q <= RD;
            end else if (DTam == 2'b00) begin
              memwr_q    <= 1'b1;
              memwdata_q <= DWData;
              state_q    <= WR;
            end else begin
              state_q <= RMW_RD;
            end
          end
        end
        RD: begin
          if (lat_done) begin
            if (gnt_q) begin
              irdata_q <= IAddr[2] ? MemRData[63:32] : MemRData[31:0];
              iack_q   <= 1'b1;
            end else begin
              drdata_q <= ld_lane;
              dack_q   <= 1'b1;
            end
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RMW_RD: begin
          if (lat_done) begin
            memwdata_q <= merged;
            memwr_q    <= 1'b1;
            state_q    <= RMW_WR;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RMW_WR, WR: begin
          dack_q  <= 1'b1;
          state_q <= ACK;
        end
        ACK: begin
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IAck     = iack_q;
  assign IRData   = irdata_q;
  assign DAck     = dack_q;
  assign DRData   = drdata_q;
  assign DErr     = derr_q;
  assign MemAddr  = memaddr_q;
  assign MemWData = memwdata_q;
  assign MemWr    = memwr_q;
  assign Busy     = (state_q != IDLE);
  assign ArbState = state_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single-ported unified memory of the multicycle core. It accepts requests from the instruction-fetch path and the load/store path, and grants one at a time with round-robin fairness. It issues the memory cycle, including read-modify-write for sub-doubleword stores, and returns a one-cycle acknowledge to the winner. It sits between the control unit/datapath registers (IR, MDR) and the memory macro.

## Interface
- DATA_W, 64, memory word width in bits; must be 64 (8 byte lanes).
- MEM_LAT, 1, read latency in cycles from MemAddr valid to MemRData valid; range 1..3.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IReq  in  1  fetch request; held until IAck.
- IAddr  in  32  fetch byte address; bits [1:0] ignored.
- IAck  out  1  one-cycle pulse; IRData valid in the same cycle.
- IRData  out  32  the 32-bit instruction lane selected by IAddr[2].
- DReq  in  1  data request; held, with DWe/DAddr/DWData/DTam stable, until DAck or DErr.
- DWe  in  1  1 = store, 0 = load.
- DAddr  in  32  data byte address.
- DWData  in  DATA_W  store data, right-justified.
- DTam  in  2  access size: 00 = doubleword, 01 = word, 10 = half, 11 = byte.
- DAck  out  1  one-cycle completion pulse.
- DRData  out  DATA_W  load lane, right-justified and zero-extended; valid with DAck.
- DErr  out  1  one-cycle misalignment pulse; no memory access is made.
- MemAddr  out  32  doubleword-aligned address ({DAddr[31:3],3'b0} or {IAddr[31:3],3'b0}).
- MemWData  out  DATA_W  write data.
- MemWr  out  1  write strobe, one cycle per write.
- MemRData  in  DATA_W  read data.
- Busy  out  1  high in any state other than IDLE.
- ArbState  out  3  current FSM state, for debug.

## Operation
- FSM states: IDLE, CHK, RD, RMW_RD, RMW_WR, WR, ACK.
- IDLE: sample IReq/DReq. A single request is granted directly. If both are high, grant the requester not granted last; `last` resets to data, so fetch wins the first tie. Move to CHK.
- CHK (data only; a fetch goes straight to RD):
  - Misaligned if DTam=01 and DAddr[1:0]≠0; DTam=10 and DAddr[0]≠0; DTam=00 and DAddr[2:0]≠0.
  - If misaligned: pulse DErr, go to IDLE.
  - Otherwise: load → RD; store with DTam=00 → WR; sub-doubleword store → RMW_RD.
- RD: drive MemAddr and wait MEM_LAT cycles, then capture MemRData and go to ACK.
- WR: drive MemAddr, MemWData=DWData and MemWr=1 for one cycle, then go to ACK.
- RMW_RD: like RD, but the captured word is kept internally. Then go to RMW_WR.
- RMW_WR: merge DWData's low 1/2/4 bytes into the captured word at byte offset DAddr[2:0]. Drive MemWr=1 with the merged word for one cycle, then go to ACK.
- Load data extraction:
  - DTam=00: DRData = word.
  - DTam=01: DRData = 32 bits at offset DAddr[2].
  - DTam=10: DRData = 16 bits at DAddr[2:1].
  - DTam=11: DRData = 8 bits at DAddr[2:0].
  - All lanes are zero-extended.
- Fetch data: IRData = MemRData[63:32] if IAddr[2], else [31:0].
- ACK: pulse IAck or DAck for the granted side, update `last`, go to IDLE.
- A request still high in the cycle after its ack is treated as a new request.
- Req dropped before ack: protocol violation; behaviour undefined. The bench asserts it never occurs.

## Timing
- Request sampled in IDLE at edge t. MemAddr/MemWr are registered and appear from t+1 (fetch) or t+2 (data, after CHK).
- Fetch read: IAck at t+2+MEM_LAT (t+3 at MEM_LAT=1).
- Data load: DAck at t+3+MEM_LAT.
- Data doubleword store: MemWr at t+2, DAck at t+3.
- Sub-doubleword store: MemWr at t+3+MEM_LAT, DAck at t+4+MEM_LAT.
- Misaligned access: DErr at t+2; MemWr never asserted.
- Minimum gap between two grants: one IDLE cycle.
- Reset, whether idle or mid-operation, takes effect immediately and asynchronously:
  - State returns to IDLE and `last` returns to data.
  - All outputs go to 0, with MemWr dropping in the same cycle.
  - Any in-flight request is discarded and must be reissued by its requester.

## Test plan
- Fetch only, MEM_LAT=1, IAddr=0x0000_0014, memory word 0xAAAA_BBBB_CCCC_DDDD → IAck at t+3, IRData=0xAAAA_BBBB, MemWr stays 0.
- Simultaneous IReq and DReq out of reset → fetch acked first, then data. On a second tie, data is acked first.
- Byte store DAddr=0x103, DWData=0xEF, old word 0x1122_3344_5566_7788 → one read, then one MemWr with 0x1122_3344_EF66_7788, DAck at t+5.
- Half load DAddr=0x106, word 0x8765_4321_0000_0000 → DRData=0x0000_0000_0000_8765.
- Word access DAddr=0x102 → DErr pulse at t+2, no MemWr, FSM in IDLE at t+3.
- Reset asserted during RMW_RD → MemWr=0, Busy=0 and ArbState=IDLE immediately. After release, the reissued request completes normally.
